uart_tx_engine: RTL and testbench

Parametrised, buffered UART transmitter with runtime frame format: 5–MAX_BITS data bits, none/even/odd parity, 1 or 2 stop bits, and a programmable baud divisor. It contains its own FIFO and a frame FSM with back-to-back transmission. It sits between the memory-mapped UART register block (write side) and the serial pin. It is the drop-in successor to the fixed-format 8-bit transmitter path.

---
 rtl/uart_pkg.sv | 40 ++++
 rtl/uart_tx_fifo.sv | 63 ++++++
 rtl/uart_tx_engine.sv | 170 +++++++++++++++++
 tb/tb_uart_tx_engine.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by the UART transmit path.
//   tx_state_t      frame FSM state encoding (values fixed for legacy tools)
//   CHAR_MIN        narrowest legal character
//   PAR_*           latched parity mode {enable, odd}
//   clamp_char_len  maps an out-of-range character length to the widest one
package uart_pkg;

  localparam int unsigned CHAR_MIN = 5;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b10;
  localparam logic [1:0] PAR_ODD  = 2'b11;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP1  = 3'd4;
  localparam logic [2:0] ST_STOP2  = 3'd5;
  localparam logic [2:0] ST_BREAK  = 3'd6;
  localparam logic [2:0] ST_BRKEND = 3'd7;

  typedef enum logic [2:0] {
    TX_IDLE   = ST_IDLE,
    TX_START  = ST_START,
    TX_DATA   = ST_DATA,
    TX_PARITY = ST_PARITY,
    TX_STOP1  = ST_STOP1,
    TX_STOP2  = ST_STOP2,
    TX_BREAK  = ST_BREAK,
    TX_BRKEND = ST_BRKEND
  } tx_state_t;

  function automatic logic [3:0] clamp_char_len(input logic [3:0] len,
                                                input int unsigned max_bits);
    if (32'(len) < CHAR_MIN || 32'(len) > max_bits) return 4'(max_bits);
    return len;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO for the UART transmitter.
//   clk, reset   clock, async active-high reset
//   push_i       write wdata_i (dropped when full unless popping)
//   pop_i        remove the head entry; rdata_o shows the head combinationally
//   level_o      registered entry count; full_o/empty_o registered flags
//   overflow_o   one-cycle pulse the cycle after a dropped write
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic                   overflow_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [LW-1:0]    level_q, level_d;
  logic             full_q, empty_q, ovf_q;
  logic             do_pop, accept;

  assign do_pop  = pop_i && !empty_q;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign accept  = push_i && (!full_q || do_pop);
  assign level_d = level_q + LW'(accept) - LW'(do_pop);

  always_ff @(posedge clk) begin
    if (accept) mem_q[wptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      if (accept) wptr_q <= wptr_q + AW'(1);
      if (do_pop) rptr_q <= rptr_q + AW'(1);
      level_q <= level_d;
      full_q  <= (level_d == LW'(DEPTH));
      empty_q <= (level_d == '0);
      ovf_q   <= push_i && !accept;
    end
  end

  assign rdata_o    = mem_q[rptr_q];
  assign level_o    = level_q;
  assign full_o     = full_q;
  assign empty_o    = empty_q;
  assign overflow_o = ovf_q;
endmodule

// File: rtl/uart_tx_engine.sv
// uart_tx_engine: buffered UART transmitter with runtime frame format.
//   clk, reset          clock, async active-high reset
//   wr_en, wr_data      push a character (LSB first on the line)
//   char_len            data bits (5..MAX_BITS, others treated as MAX_BITS)
//   parity_en/odd       optional parity bit, odd when parity_odd
//   stop2               two stop bits
//   baud_div            bit period = baud_div+1 clocks
//   tx                  registered serial line, idle high
//   busy                frame FSM not idle
//   fifo_full/empty/level, overflow   FIFO status
// Optional: define UART_TX_BREAK_EN to add input brk (line break generation).
//
// state  | meaning
// IDLE   | line high, pops FIFO when not empty
// START  | start bit (0)
// DATA   | char_len data bits, LSB first
// PARITY | parity bit
// STOP1  | first stop bit; ends frame unless stop2
// STOP2  | second stop bit
// BREAK  | line held low while brk is high
// BRKEND | one high bit period after a break, then IDLE
module uart_tx_engine import uart_pkg::*; #(
  parameter int MAX_BITS   = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 12
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_en,
  input  logic [MAX_BITS-1:0]         wr_data,
  input  logic [3:0]                  char_len,
  input  logic                        parity_en,
  input  logic                        parity_odd,
  input  logic                        stop2,
  input  logic [DIV_W-1:0]            baud_div,
`ifdef UART_TX_BREAK_EN
  input  logic                        brk,
`endif
  output logic                        tx,
  output logic                        busy,
  output logic                        fifo_full,
  output logic                        fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow
);
  tx_state_t           state_q, state_d;
  logic [DIV_W-1:0]    cnt_q, cnt_d;
  logic [MAX_BITS-1:0] shift_q, shift_d;
  logic [3:0]          bit_q, bit_d, len_q, len_d;
  logic [1:0]          mode_q, mode_d;
  logic                stop2_q, stop2_d, par_q, par_d, tx_q, tx_d;
  logic                tick, pop, next_frame;
  logic [MAX_BITS-1:0] head;

  uart_tx_fifo #(.WIDTH(MAX_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_i    (wr_en),
    .wdata_i   (wr_data),
    .pop_i     (pop),
    .rdata_o   (head),
    .level_o   (fifo_level),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .overflow_o(overflow)
  );

  assign tick = (cnt_q == baud_div);

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_d      = bit_q;
    len_d      = len_q;
    mode_d     = mode_q;
    stop2_d    = stop2_q;
    par_d      = par_q;
    pop        = 1'b0;
    next_frame = 1'b0;

    if (state_q == TX_IDLE || state_q == TX_BREAK) cnt_d = '0;
    else if (tick)                                 cnt_d = '0;
    else                                           cnt_d = cnt_q + DIV_W'(1);

    case (state_q)
      TX_IDLE:   next_frame = 1'b1;
      TX_START:  if (tick) state_d = TX_DATA;
      TX_DATA: begin
        if (tick) begin
          par_d   = par_q ^ shift_q[0];
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 4'd1;
          if (bit_q == len_q - 4'd1)
            state_d = (mode_q != PAR_NONE) ? TX_PARITY : TX_STOP1;
        end
      end
      TX_PARITY: if (tick) state_d = TX_STOP1;
      TX_STOP1: begin
        if (tick) begin
          if (stop2_q) state_d = TX_STOP2;
          else         next_frame = 1'b1;
        end
      end
      TX_STOP2:  if (tick) next_frame = 1'b1;
`ifdef UART_TX_BREAK_EN
      TX_BREAK:  if (!brk) state_d = TX_BRKEND;
      TX_BRKEND: if (tick) state_d = TX_IDLE;
`endif
      default:   state_d = TX_IDLE;
    endcase

    // Shared by IDLE and the last stop tick so frames run back-to-back.
    if (next_frame) begin
      state_d = TX_IDLE;
      if (!fifo_empty) begin
        pop     = 1'b1;
        shift_d = head;
        bit_d   = '0;
        len_d   = clamp_char_len(char_len, MAX_BITS);
        mode_d  = parity_en ? (parity_odd ? PAR_ODD : PAR_EVEN) : PAR_NONE;
        stop2_d = stop2;
        par_d   = parity_odd;
        state_d = TX_START;
      end
`ifdef UART_TX_BREAK_EN
      if (brk) begin
        pop     = 1'b0;
        state_d = TX_BREAK;
      end
`endif
    end

    case (state_d)
      TX_START:  tx_d = 1'b0;
      TX_DATA:   tx_d = shift_d[0];
      TX_PARITY: tx_d = par_d;
`ifdef UART_TX_BREAK_EN
      TX_BREAK:  tx_d = 1'b0;
`endif
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      bit_q   <= '0;
      len_q   <= '0;
      mode_q  <= PAR_NONE;
      stop2_q <= 1'b0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      len_q   <= len_d;
      mode_q  <= mode_d;
      stop2_q <= stop2_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  assign tx   = tx_q;
  assign busy = (state_q != TX_IDLE);
endmodule

// File: tb/tb_uart_tx_engine.sv
// tb_uart_tx_engine: directed bench for uart_tx_engine (FIFO_DEPTH=4).
// A cycle-level line model (expected tx/busy per cycle from frame rules,
// plus a queue for the FIFO) is compared every cycle; literal waveforms and
// timings pin the model.
module tb_uart_tx_engine;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_data = '0;
  logic [3:0]  char_len = 4'd8;
  logic        parity_en = 1'b0;
  logic        parity_odd = 1'b0;
  logic        stop2 = 1'b0;
  logic [11:0] baud_div = '0;
`ifdef UART_TX_BREAK_EN
  logic        brk = 1'b0;
`endif
  logic        tx, busy, fifo_full, fifo_empty, overflow;
  logic [2:0]  fifo_level;

  uart_tx_engine #(.MAX_BITS(8), .FIFO_DEPTH(DEPTH), .DIV_W(12)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .char_len(char_len), .parity_en(parity_en), .parity_odd(parity_odd),
    .stop2(stop2), .baud_div(baud_div),
`ifdef UART_TX_BREAK_EN
    .brk(brk),
`endif
    .tx(tx), .busy(busy), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .fifo_level(fifo_level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- model ----------------
  logic       model_on = 1'b1;
  logic       line[$];
  logic [7:0] mfifo[$];
  logic       ovf_exp = 1'b0;
  logic       e_tx;

  function automatic void add_frame(input logic [7:0] ch);
    int   n;
    logic p;
    logic b[$];
    n = (char_len < 4'd5 || char_len > 4'd8) ? 8 : int'(char_len);
    p = parity_odd;
    b.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      b.push_back(ch[i]);
      p = p ^ ch[i];
    end
    if (parity_en) b.push_back(p);
    b.push_back(1'b1);
    if (stop2) b.push_back(1'b1);
    foreach (b[k])
      for (int r = 0; r <= int'(baud_div); r++) line.push_back(b[k]);
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_tx", 64'(tx), 64'd1);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_empty", 64'(fifo_empty), 64'd1);
      chk("rst_full", 64'(fifo_full), 64'd0);
      chk("rst_level", 64'(fifo_level), 64'd0);
      chk("rst_ovf", 64'(overflow), 64'd0);
      line.delete();
      mfifo.delete();
      ovf_exp = 1'b0;
    end else if (model_on) begin
      e_tx = (line.size() != 0) ? line[0] : 1'b1;
      chk("m_tx", 64'(tx), 64'(e_tx));
      chk("m_busy", 64'(busy), 64'(line.size() != 0));
      chk("m_level", 64'(fifo_level), 64'(mfifo.size()));
      chk("m_empty", 64'(fifo_empty), 64'(mfifo.size() == 0));
      chk("m_full", 64'(fifo_full), 64'(mfifo.size() == DEPTH));
      chk("m_ovf", 64'(overflow), 64'(ovf_exp));
      if (line.size() != 0) void'(line.pop_front());
      // Line free for the next cycle and something queued: pop now.
      if (line.size() == 0 && mfifo.size() != 0) add_frame(mfifo.pop_front());
      ovf_exp = 1'b0;
      if (wr_en) begin
        if (mfifo.size() < DEPTH) mfifo.push_back(wr_data);
        else ovf_exp = 1'b1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [7:0] d);
    wr_en = 1'b1;
    wr_data = d;
    step(1);
    wr_en = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 500) begin
      n++;
      step(1);
    end
  endtask

  logic [39:0] cap40;
  logic [21:0] cap22;
  int          nb;

  initial begin
    step(3);
    reset = 1'b0;
    step(2);

    // 8N1, baud_div=3, 0xA5
    baud_div = 12'd3;
    write(8'hA5);
    chk("t1_empty_n1", 64'(fifo_empty), 64'd0);
    chk("t1_level_n1", 64'(fifo_level), 64'd1);
    chk("t1_busy_n1", 64'(busy), 64'd0);
    step(1);
    chk("t1_busy_n2", 64'(busy), 64'd1);
    for (int i = 0; i < 40; i++) begin
      cap40[39-i] = tx;
      step(1);
    end
    chk("t1_wave", 64'(cap40), 64'h0F0F00F0FF);
    chk("t1_busy_end", 64'(busy), 64'd0);
    step(3);

    // 7O2, baud_div=1, 0x53
    char_len = 4'd7; parity_en = 1'b1; parity_odd = 1'b1; stop2 = 1'b1; baud_div = 12'd1;
    write(8'h53);
    step(1);
    for (int i = 0; i < 22; i++) begin
      cap22[21-i] = tx;
      step(1);
    end
    chk("t2_wave", 64'(cap22), 64'(22'b0011110000110011111111));
    chk("t2_busy_end", 64'(busy), 64'd0);
    step(3);

    // six back-to-back writes into a 4-deep FIFO, 8N1, baud_div=0
    char_len = 4'd8; parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0; baud_div = 12'd0;
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1;
      wr_data = 8'h10 + 8'(i);
      step(1);
      if (i == 4) begin
        chk("t3_full", 64'(fifo_full), 64'd1);
        chk("t3_level", 64'(fifo_level), 64'd4);
      end
    end
    wr_en = 1'b0;
    chk("t3_ovf_pulse", 64'(overflow), 64'd1);
    step(1);
    chk("t3_ovf_clear", 64'(overflow), 64'd0);
    count_busy(nb);
    chk("t3_busy_run", 64'(nb), 64'd45);
    step(3);

    // two writes, baud_div=0 -> 20 busy cycles
    write(8'h3C);
    write(8'hC3);
    count_busy(nb);
    chk("t4_busy_run", 64'(nb), 64'd20);
    step(3);

    // reset in the middle of DATA with a second character queued
    baud_div = 12'd3;
    write(8'h5A);
    write(8'h77);
    step(8);
    chk("t5_busy_pre", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    chk("t5_tx", 64'(tx), 64'd1);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_empty", 64'(fifo_empty), 64'd1);
    chk("t5_level", 64'(fifo_level), 64'd0);
    step(2);
    reset = 1'b0;
    nb = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy) nb++;
      step(1);
    end
    chk("t5_quiet", 64'(nb), 64'd0);
    write(8'h0F);
    step(1);
    count_busy(nb);
    chk("t5_new_frame", 64'(nb), 64'd40);
    step(3);

    // out-of-range char_len (3 -> 8), even parity, baud_div=2; config changes mid-frame
    char_len = 4'd3; parity_en = 1'b1; parity_odd = 1'b0; baud_div = 12'd2;
    write(8'h3C);
    step(1);
    char_len = 4'd5; parity_en = 1'b0;
    count_busy(nb);
    chk("t6_busy_run", 64'(nb), 64'd33);
    step(3);
    char_len = 4'd8;

`ifdef UART_TX_BREAK_EN
    model_on = 1'b0;
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    baud_div = 12'd1;
    step(2);
    write(8'h00);
    step(4);
    brk = 1'b1;
    write(8'h81);
    step(15);
    chk("brk_last_stop_tx", 64'(tx), 64'd1);
    chk("brk_last_stop_busy", 64'(busy), 64'd1);
    for (int i = 0; i < 9; i++) begin
      step(1);
      chk("brk_low_tx", 64'(tx), 64'd0);
      chk("brk_low_busy", 64'(busy), 64'd1);
    end
    brk = 1'b0;
    step(1);
    chk("brk_end1_tx", 64'(tx), 64'd1);
    chk("brk_end1_busy", 64'(busy), 64'd1);
    step(1);
    chk("brk_end2_tx", 64'(tx), 64'd1);
    step(1);
    chk("brk_idle_busy", 64'(busy), 64'd0);
    step(1);
    chk("brk_next_start", 64'(tx), 64'd0);
    chk("brk_next_busy", 64'(busy), 64'd1);
    step(25);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
